proc_phase_gen: RTL and testbench

//  Downstream of the processor's divided-clock source. From the base clk, generates phase strobes
//  for the single-cycle processor: imem fetch, dmem access, and processor/regfile commit.

---
 rtl/proc_clk_pkg.sv | 33 +++
 rtl/proc_phase_gen_phase_counter.sv | 43 ++++
 rtl/proc_phase_gen.sv | 119 +++++++++++
 tb/tb_proc_phase_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_clk_pkg.sv
// Shared types and helpers for the processor phase generator.
// Phase indices are derived from DIV in each user.
package proc_clk_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    HALTED,
    STEP
  } state_e;

  localparam int DIV_DEF   = 4;
  localparam int PH_FETCH  = 0;
  localparam int PH_MEM    = DIV_DEF / 2;
  localparam int PH_COMMIT = DIV_DEF - 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ph_mem(input int div);
    return div / 2;
  endfunction

  function automatic int ph_commit(input int div);
    return div - 1;
  endfunction

endpackage

// File: rtl/proc_phase_gen_phase_counter.sv
// Mod-DIV phase counter with enable, clear and wrap flag.
// Also exposes the next phase for registered consumers.
module phase_counter
  import proc_clk_pkg::*;
#(
  parameter int DIV = 4,
  localparam int PW = clog2(DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [PW-1:0] phase_o,
  output logic [PW-1:0] phase_d_o,
  output logic          wrap_o
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  assign wrap_o = en_i & (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clr_i)
      phase_d = '0;
    else if (wrap_o)
      phase_d = '0;
    else if (en_i)
      phase_d = phase_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign phase_o   = phase_q;
  assign phase_d_o = phase_d;

endmodule

// File: rtl/proc_phase_gen.sv
// Phase strobes, divided clock and reset/halt/step sequencing.
// Optional cycle counter: PHASE_GEN_CYCLE_COUNT_EN.
module proc_phase_gen
  import proc_clk_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int RST_HOLD = 2,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt_req,
  input  logic                   step_req,
  output logic                   proc_rst,
  output logic                   halted,
  output logic [clog2(DIV)-1:0]  phase,
  output logic                   imem_en,
  output logic                   dmem_en,
  output logic                   proc_en,
  output logic                   clk_slow,
  output logic [CNT_W-1:0]       cyc_count
);

  localparam int PW = clog2(DIV);
  localparam int HW = clog2(RST_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
    $error("proc_phase_gen: DIV must be even and >= 2");
  end
  if (RST_HOLD < 1) begin : g_bad_hold
    $error("proc_phase_gen: RST_HOLD must be >= 1");
  end

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          slow_q, slow_d;
  logic [PW-1:0] phase_d;
  logic          wrap;
  logic          active_q, active_d;
  logic          run_q;

  assign active_q = (state_q != HALTED);
  assign active_d = (state_d != HALTED);
  assign run_q    = (state_q == RUN) || (state_q == STEP);

  phase_counter #(.DIV(DIV)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .en_i      (active_q),
    .clr_i     (state_q == HALTED),
    .phase_o   (phase),
    .phase_d_o (phase_d),
    .wrap_o    (wrap)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      HOLD: begin
        if (wrap) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = halt_req ? HALTED : RUN;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      RUN, STEP: begin
        if (wrap) state_d = halt_req ? HALTED : RUN;
      end
      HALTED: begin
        // Dropping halt wins over a concurrent step request
        if (!halt_req)     state_d = RUN;
        else if (step_req) state_d = STEP;
      end
      default: state_d = HOLD;
    endcase
  end

  assign slow_d = active_d & (phase_d < PW'(DIV / 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      hold_q  <= '0;
      slow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      slow_q  <= slow_d;
    end
  end

  assign proc_rst = (state_q == HOLD);
  assign halted   = (state_q == HALTED);
  assign clk_slow = slow_q;
  assign imem_en  = run_q & (phase == PW'(PH_FETCH));
  assign dmem_en  = run_q & (phase == PW'(ph_mem(DIV)));
  assign proc_en  = run_q & (phase == PW'(ph_commit(DIV)));

`ifdef PHASE_GEN_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cyc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cyc_q <= '0;
    else if (proc_en && (cyc_q != '1))
      cyc_q <= cyc_q + CNT_W'(1);
  end

  assign cyc_count = cyc_q;
`else
  assign cyc_count = '0;
`endif

endmodule

// File: tb/tb_proc_phase_gen.sv
// Bench for proc_phase_gen: directed scenarios plus random
// halt/step/reset traffic against a cycle-level reference model.
module tb_proc_phase_gen;

  localparam int DIV      = 4;
  localparam int RST_HOLD = 2;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PHASE_GEN_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt_req = 1'b0;
  logic step_req = 1'b0;
  logic proc_rst, halted, imem_en, dmem_en, proc_en, clk_slow;
  logic [1:0] phase;
  logic [CNT_W-1:0] cyc_count;

  int n_chk = 0;
  int n_fail = 0;

  int m_ph = 0;
  bit m_hold = 1'b1;
  bit m_halt = 1'b0;
  int m_done = 0;
  int m_cnt = 0;
  bit m_slow = 1'b0;

  proc_phase_gen #(.DIV(DIV), .RST_HOLD(RST_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .proc_rst  (proc_rst),
    .halted    (halted),
    .phase     (phase),
    .imem_en   (imem_en),
    .dmem_en   (dmem_en),
    .proc_en   (proc_en),
    .clk_slow  (clk_slow),
    .cyc_count (cyc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a processor cycle is DIV clks; hold lasts RST_HOLD
  // cycles; halt is sampled at cycle ends; a step is a one-cycle run.
  always @(posedge clk) begin
    bit commit;
    #1;
    if (reset) begin
      m_ph = 0; m_hold = 1; m_halt = 0;
      m_done = 0; m_cnt = 0; m_slow = 0;
    end else begin
      commit = !m_hold && !m_halt && (m_ph == DIV - 1);
      if (commit && m_cnt < CNT_MAX) m_cnt++;
      if (m_halt) begin
        m_halt = halt_req && !step_req;
      end else if (m_ph == DIV - 1) begin
        m_ph = 0;
        if (m_hold) begin
          m_done++;
          if (m_done == RST_HOLD) begin
            m_hold = 0;
            m_halt = halt_req;
          end
        end else begin
          m_halt = halt_req;
        end
      end else begin
        m_ph++;
      end
      m_slow = !m_halt && (m_ph < DIV / 2);
    end
    check("m_proc_rst", int'(proc_rst), int'(m_hold));
    check("m_halted", int'(halted), int'(m_halt));
    check("m_phase", int'(phase), m_ph);
    check("m_imem", int'(imem_en), int'(!m_hold && !m_halt && m_ph == 0));
    check("m_dmem", int'(dmem_en), int'(!m_hold && !m_halt && m_ph == DIV/2));
    check("m_proc", int'(proc_en), int'(!m_hold && !m_halt && m_ph == DIV-1));
    check("m_slow", int'(clk_slow), int'(m_slow));
    check("m_cyc", int'(cyc_count), CNT_EN ? m_cnt : 0);
  end

  task automatic edge2();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] slow_pat;
    int c_i, c_d, c_p;
    bit found;
    slow_pat = 4'b0011;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t1_rst0", int'(proc_rst), 1);
    check("t1_imem0", int'(imem_en), 0);
    for (int i = 0; i < 7; i++) begin
      edge2();
      check("t1_rst_hold", int'(proc_rst), 1);
      check("t1_no_strobe", int'(imem_en | dmem_en | proc_en), 0);
    end
    edge2();
    check("t1_rst_fall", int'(proc_rst), 0);
    check("t1_phase0", int'(phase), 0);
    check("t1_imem", int'(imem_en), 1);

    for (int k = 0; k < 8; k++) begin
      if (k != 0) edge2();
      check("t2_imem", int'(imem_en), int'(k % 4 == 0));
      check("t2_dmem", int'(dmem_en), int'(k % 4 == 2));
      check("t2_proc", int'(proc_en), int'(k % 4 == 3));
      check("t2_slow", int'(clk_slow), int'(slow_pat[k % 4]));
    end

    edge2();
    edge2();
    check("t3_phase1", int'(phase), 1);
    @(negedge clk);
    halt_req = 1'b1;
    edge2();
    check("t3_dmem", int'(dmem_en), 1);
    edge2();
    check("t3_proc", int'(proc_en), 1);
    edge2();
    check("t3_halted", int'(halted), 1);
    check("t3_phase", int'(phase), 0);
    for (int i = 0; i < 3; i++) begin
      edge2();
      check("t3_quiet", int'(imem_en | dmem_en | proc_en | clk_slow), 0);
    end

    c_i = 0; c_d = 0; c_p = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      step_req = (i == 0 || i == 2);
      edge2();
      c_i += int'(imem_en);
      c_d += int'(dmem_en);
      c_p += int'(proc_en);
    end
    step_req = 1'b0;
    check("t4_imem_cnt", c_i, 1);
    check("t4_dmem_cnt", c_d, 1);
    check("t4_proc_cnt", c_p, 1);
    check("t4_halted", int'(halted), 1);

    @(negedge clk);
    halt_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      edge2();
      if (phase == 2'd2) found = 1'b1;
    end
    check("t5_reach_ph2", int'(found), 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t5_rst", int'(proc_rst), 1);
    check("t5_strobes", int'(imem_en | dmem_en | proc_en), 0);
    check("t5_slow", int'(clk_slow), 0);
    check("t5_phase", int'(phase), 0);
    check("t5_halted", int'(halted), 0);
    @(negedge clk);
    reset = 1'b0;

    repeat (8 + 40) @(posedge clk);
    #2;
    check("t6_cyc10", int'(cyc_count), CNT_EN ? 10 : 0);
    repeat (40) @(posedge clk);
    #2;
    check("t6_cyc_sat", int'(cyc_count), CNT_EN ? 15 : 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
      step_req = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    step_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
